// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_arb_pkg : shared types and helpers for the memory burst arbiter |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } t_arb_state;

  localparam int BYTE_OFFSET_W = 2;

  function automatic int line_offset_w(input int block_words);
    return $clog2(block_words) + BYTE_OFFSET_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_arbiter_2 : two-way round-robin grant with last-grant register   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       arstn,
  input  logic       i_en,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_owner,
  output logic [1:0] o_grant
);

  logic r_last_grant;

  // On a conflict the requester that was not served last wins.
  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_grant = 2'b01;
        2'b10:   o_grant = 2'b10;
        2'b11:   o_grant = r_last_grant ? 2'b01 : 2'b10;
        default: o_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_last_grant <= 1'b0;
    end else if (i_update) begin
      r_last_grant <= i_owner;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_burst_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_burst_arbiter : shares one word-wide memory port between two    |
// | cache refill requesters as line-sized bursts.           Rev 1.0     |
// +--------------------------------------------------------------------+
module mem_burst_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_req0_valid,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  output logic                  o_req0_ready,
  output logic                  o_rd0_valid,
  output logic                  o_done0,
  input  logic                  i_req1_valid,
  input  logic                  i_req1_write,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_req1_ready,
  output logic                  o_rd1_valid,
  output logic                  o_wr1_next,
  output logic                  o_done1,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_mem_write_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_successful_read,
  input  logic                  i_mem_successful_write
);

  localparam int c_OFF_W  = line_offset_w(BLOCK_WORDS);
  localparam int c_BEAT_W = c_OFF_W - BYTE_OFFSET_W;
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BLOCK_WORDS - 1);

  t_arb_state                      r_state;
  logic [c_BEAT_W-1:0]             r_beat;
  logic [ADDR_WIDTH-c_OFF_W-1:0]   r_line;
  logic                            r_owner;
  logic                            r_write;

  logic [1:0]                      w_grant;
  logic [ADDR_WIDTH-c_OFF_W-1:0]   w_req_line;
  logic                            w_burst;
  logic                            w_rd;
  logic                            w_wr;
  logic                            w_beat_ok;
  logic                            w_unused;

  // Gating with arstn keeps the ready pulses low while reset is held.
  rr_arbiter_2 u_rr (
    .clk      (clk),
    .arstn    (arstn),
    .i_en     ((r_state == IDLE) && arstn),
    .i_req    ({i_req1_valid, i_req0_valid}),
    .i_update (r_state == DONE),
    .i_owner  (r_owner),
    .o_grant  (w_grant)
  );

  assign w_req_line = w_grant[1] ? i_req1_addr[ADDR_WIDTH-1:c_OFF_W]
                                 : i_req0_addr[ADDR_WIDTH-1:c_OFF_W];
  assign w_unused   = ^{i_req0_addr[c_OFF_W-1:0], i_req1_addr[c_OFF_W-1:0]};

  assign w_burst   = (r_state == BURST);
  assign w_rd      = w_burst && !r_write;
  assign w_wr      = w_burst && r_write;
  assign w_beat_ok = r_write ? i_mem_successful_write : i_mem_successful_read;

  assign o_req0_ready   = w_grant[0];
  assign o_req1_ready   = w_grant[1];
  assign o_rd0_valid    = w_rd && !r_owner && i_mem_successful_read;
  assign o_rd1_valid    = w_rd && r_owner && i_mem_successful_read;
  assign o_wr1_next     = w_wr && i_mem_successful_write;
  assign o_done0        = (r_state == DONE) && !r_owner;
  assign o_done1        = (r_state == DONE) && r_owner;
  assign o_rd_data      = w_rd ? i_mem_data : '0;
  assign o_mem_write_en = w_wr;
  assign o_mem_data     = w_wr ? i_req1_wdata : '0;
  // Beat index replaces the word-offset field, so the burst never leaves the line.
  assign o_mem_addr     = w_burst ? {r_line, r_beat, {BYTE_OFFSET_W{1'b0}}} : '0;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_line  <= '0;
      r_owner <= 1'b0;
      r_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_line  <= w_req_line;
            r_owner <= w_grant[1];
            r_write <= w_grant[1] && i_req1_write;
            r_beat  <= '0;
            r_state <= BURST;
          end
        end
        BURST: begin
          if (w_beat_ok) begin
            if (r_beat == c_LAST_BEAT) begin
              r_state <= DONE;
            end else begin
              r_beat <= r_beat + c_BEAT_W'(1);
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Sequences and shares the single word-wide external memory port between two requesters.
- Requester 0: instruction-cache line refill, read only. Requester 1: data-cache line refill or writeback.
- Each granted request becomes a burst of BLOCK_WORDS sequential word accesses to one line-aligned block.
- Sits between the cache controllers and the memory model / memory interface.

Parameters:
- DATA_WIDTH, 32, memory word width in bits.
- ADDR_WIDTH, 64, byte address width.
- BLOCK_WORDS, 16, words per cache line; power of two, at least 2.

Ports:
- clk  in  1  clock.
- arstn  in  1  reset, asynchronous, active-low.
- i_req0_valid  in  1  requester 0 line-read request.
- i_req0_addr  in  ADDR_WIDTH  requester 0 byte address; any byte inside the line.
- o_req0_ready  out  1  one-cycle pulse: request 0 accepted.
- o_rd0_valid  out  1  o_rd_data is a beat for requester 0.
- o_done0  out  1  one-cycle pulse: requester 0 burst complete.
- i_req1_valid  in  1  requester 1 request.
- i_req1_write  in  1  1 = line write, 0 = line read.
- i_req1_addr  in  ADDR_WIDTH  requester 1 byte address.
- i_req1_wdata  in  DATA_WIDTH  current write beat; requester advances it on o_wr1_next.
- o_req1_ready  out  1  one-cycle pulse: request 1 accepted.
- o_rd1_valid  out  1  o_rd_data is a beat for requester 1.
- o_wr1_next  out  1  current write beat consumed.
- o_done1  out  1  one-cycle pulse: requester 1 burst complete.
- o_rd_data  out  DATA_WIDTH  read beat data, shared by both requesters.
- o_mem_write_en  out  1  memory write enable.
- o_mem_addr  out  ADDR_WIDTH  memory byte address.
- o_mem_data  out  DATA_WIDTH  memory write data.
- i_mem_data  in  DATA_WIDTH  memory read data; combinational from o_mem_addr.
- i_mem_successful_read  in  1  read beat completed this cycle.
- i_mem_successful_write  in  1  write beat lands on this clock edge.

Behaviour:
- Reset (async, arstn low):
  - state = IDLE, beat = 0, owner = 0, last_grant = 0.
  - All outputs 0, including o_mem_write_en, which must deassert immediately without waiting for clk.
- FSM states: IDLE, BURST, DONE.
- IDLE:
  - Only one request valid: grant it.
  - Both valid: grant the requester that is not last_grant. After reset, requester 1 wins the first conflict.
  - On grant:
    - Pulse o_reqN_ready in that cycle (combinational from IDLE and the grant).
    - On the clock edge, latch base = addr with low log2(BLOCK_WORDS)+2 bits cleared, owner, and write flag. For requester 0 the write flag is forced to 0.
    - beat = 0, go to BURST.
- BURST:
  - o_mem_addr = base + beat*4. Low offset bits are replaced, not added, so there is no carry out of the line.
  - Read:
    - o_rd_data = i_mem_data, and o_rdN_valid (owner) = i_mem_successful_read.
    - On success, beat increments.
  - Write:
    - o_mem_write_en = 1 and o_mem_data = i_req1_wdata.
    - o_wr1_next = i_mem_successful_write. On success, beat increments.
  - Stall (success low): address, data and write_en are held; beat is unchanged; no valid and no next pulse.
  - A successful beat with beat == BLOCK_WORDS-1 goes to DONE.
- DONE:
  - o_doneN (owner) pulses for one cycle, last_grant = owner, go to IDLE.
  - No request is accepted in DONE.
- Latency with no stalls: accept cycle + BLOCK_WORDS beat cycles + DONE cycle = BLOCK_WORDS+2 cycles. The next grant can occur in the cycle after DONE.
- Request valid is ignored outside IDLE. Deasserting valid mid-burst does not abort the burst; it completes.
- Requester holds addr and write stable only in the accept cycle; they are latched.
- Write enable is never asserted outside BURST, and never for requester 0.
- Reset mid-burst: the transaction is abandoned, with no done pulse; the line is partially written. The next request restarts at beat 0.

Decomposition:
- Package mem_arb_pkg:
  - state enum t_arb_state {IDLE, BURST, DONE}.
  - Constant BYTE_OFFSET_W = 2.
  - Function computing the line-offset width from BLOCK_WORDS.
- Sub-module rr_arbiter_2:
  - Two-way round-robin grant logic plus the last_grant register, with last_grant update enabled by DONE.
  - Reused later for other shared ports.

Test Plan:
- Basic read, BLOCK_WORDS=4, req0 addr 0x1004, no stalls:
  - o_req0_ready in cycle 0.
  - o_mem_addr 0x1000, 0x1004, 0x1008, 0x100C in cycles 1-4, with o_rd0_valid high in each.
  - o_done0 in cycle 5.
  - o_mem_write_en never asserted.
- Write then read back: req1 write addr 0x2008, wdata beats 0xA0, 0xA1, 0xA2, 0xA3 advanced on o_wr1_next.
  - Memory words 0x2000-0x200C hold A0-A3.
  - A following req0 read of 0x2000 returns A0-A3 in order.
- Conflict: req0 and req1 both valid from reset.
  - req1 is granted first, req0 after o_done1.
  - A repeated simultaneous request after that grants req1 again (last_grant = 0); grants alternate thereafter.
- Stall: read burst with i_mem_successful_read forced low for 2 cycles at beat 1.
  - o_mem_addr held at base+4, no valid during the stall, o_done delayed by exactly 2 cycles, data order intact.
- Reset mid-burst: arstn low during write beat 2.
  - o_mem_write_en drops to 0 before the next clk edge; all outputs are 0.
  - No o_done1.
  - After release, a new req0 at 0x3000 starts at 0x3000.
- Validity churn: req0 valid deasserted in cycle 2 of its burst.
  - The burst still completes all BLOCK_WORDS beats and pulses o_done0.
